// File: rtl/mii_rx_deframer.sv
// Purpose : MII receive deframer; strips start/preamble/SFD, idles and terminate, emits sop/eop/keep frames with length and error status.
// Latency : 2 cycles from a data word being sampled to it appearing on o_data (input register + one-word hold register).
// Backpressure: none; the MII stream cannot stall, so a word is consumed or discarded every cycle.
//
// Ports:
//   clk, i_rst_n            clock, synchronous active-low reset
//   i_mii_data, i_mii_ctrl  64-bit MII word, one control bit per byte lane (lane 0 first on the wire)
//   o_data, o_keep          frame bytes and contiguous byte-valid mask
//   o_valid, o_sop, o_eop   word qualifiers
//   o_frame_len, o_runt,
//   o_err_type              per-frame status, valid with o_eop
//   o_pre_err               one-cycle pulse on a start word with a bad preamble/SFD
module mii_rx_deframer #(
    parameter int          DATA_WIDTH      = 64,
    parameter int          CTRL_WIDTH      = 8,
    parameter logic [7:0]  IDLE_CODE       = 8'h07,
    parameter logic [7:0]  START_CODE      = 8'hFB,
    parameter logic [7:0]  TERM_CODE       = 8'hFD,
    parameter logic [7:0]  PREAMBLE_CODE   = 8'h55,
    parameter logic [7:0]  SFD_CODE        = 8'hD5,
    parameter int          MIN_FRAME_BYTES = 64,
    parameter int          MAX_FRAME_BYTES = 1518
) (
    input  logic                  clk,
    input  logic                  i_rst_n,
    input  logic [DATA_WIDTH-1:0] i_mii_data,
    input  logic [CTRL_WIDTH-1:0] i_mii_ctrl,
    output logic [DATA_WIDTH-1:0] o_data,
    output logic [CTRL_WIDTH-1:0] o_keep,
    output logic                  o_valid,
    output logic                  o_sop,
    output logic                  o_eop,
    output logic [15:0]           o_frame_len,
    output logic                  o_runt,
    output logic [1:0]            o_err_type,
    output logic                  o_pre_err
);

    typedef enum logic [1:0] {ST_IDLE, ST_DATA, ST_DROP} state_t;

    localparam logic [1:0] ERR_NONE  = 2'd0;
    localparam logic [1:0] ERR_CTRL  = 2'd1;
    localparam logic [1:0] ERR_OVER  = 2'd2;
    localparam logic [1:0] ERR_START = 2'd3;

    // Input register
    logic [DATA_WIDTH-1:0] in_dat_q;
    logic [CTRL_WIDTH-1:0] in_ctl_q;

    // FSM, hold register and byte counter
    state_t                state_q, state_d;
    logic                  hold_vld_q, hold_vld_d;
    logic [DATA_WIDTH-1:0] hold_dat_q, hold_dat_d;
    logic [CTRL_WIDTH-1:0] hold_keep_q, hold_keep_d;
    logic                  hold_sop_q, hold_sop_d;
    logic                  hold_eop_q, hold_eop_d;   // held word is a terminate word awaiting emission
    logic                  sop_pend_q, sop_pend_d;   // next word entering hold is the first of the frame
    logic [15:0]           cnt_q, cnt_d;

    // Output registers
    logic [DATA_WIDTH-1:0] out_dat_q, out_dat_d;
    logic [CTRL_WIDTH-1:0] out_keep_q, out_keep_d;
    logic                  out_vld_q, out_vld_d;
    logic                  out_sop_q, out_sop_d;
    logic                  out_eop_q, out_eop_d;
    logic [15:0]           out_len_q, out_len_d;
    logic                  out_runt_q, out_runt_d;
    logic [1:0]            out_err_q, out_err_d;
    logic                  pre_err_q, pre_err_d;

    // Decode of the registered input word
    logic                  start_lead, pre_ok, all_data, all_idle, has_term, tail_ok, term_ok;
    logic [2:0]            first_ctl;
    logic [CTRL_WIDTH-1:0] term_keep;
    logic [DATA_WIDTH-1:0] term_dat;
    logic                  over_full, over_term;

    // FSM scratch
    logic                  emit, emit_eop, close, take_start;
    logic [1:0]            emit_err, close_err;

    always_comb begin
        start_lead = (in_ctl_q == 8'h01) && (in_dat_q[7:0] == START_CODE);
        pre_ok     = (in_dat_q[DATA_WIDTH-1:8] == {SFD_CODE, {6{PREAMBLE_CODE}}});
        all_data   = (in_ctl_q == '0);
        all_idle   = (in_ctl_q == '1) && (in_dat_q == {8{IDLE_CODE}});

        // Lowest lane carrying a control character
        first_ctl = 3'd0;
        for (int i = CTRL_WIDTH - 1; i >= 0; i--) begin
            if (in_ctl_q[i]) first_ctl = i[2:0];
        end

        has_term  = 1'b0;
        tail_ok   = 1'b1;
        term_keep = '0;
        term_dat  = '0;
        for (int i = 0; i < CTRL_WIDTH; i++) begin
            if (in_ctl_q[i] && (in_dat_q[8*i +: 8] == TERM_CODE)) has_term = 1'b1;
            if (i > int'(first_ctl)) begin
                if (!in_ctl_q[i] || (in_dat_q[8*i +: 8] != IDLE_CODE)) tail_ok = 1'b0;
            end
            term_keep[i]       = (i < int'(first_ctl));
            term_dat[8*i +: 8] = term_keep[i] ? in_dat_q[8*i +: 8] : 8'h00;
        end
        term_ok = (in_ctl_q != '0) && (in_dat_q[{first_ctl, 3'b000} +: 8] == TERM_CODE) && tail_ok;

        over_full = ({1'b0, cnt_q} + 17'd8) > 17'(MAX_FRAME_BYTES);
        over_term = ({1'b0, cnt_q} + {14'd0, first_ctl}) > 17'(MAX_FRAME_BYTES);
    end

    always_comb begin
        state_d     = state_q;
        hold_vld_d  = hold_vld_q;
        hold_dat_d  = hold_dat_q;
        hold_keep_d = hold_keep_q;
        hold_sop_d  = hold_sop_q;
        hold_eop_d  = hold_eop_q;
        sop_pend_d  = sop_pend_q;
        cnt_d       = cnt_q;
        pre_err_d   = 1'b0;
        emit        = 1'b0;
        emit_eop    = 1'b0;
        emit_err    = ERR_NONE;
        close       = 1'b0;
        close_err   = ERR_NONE;
        take_start  = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                // A terminate word with data lanes leaves the frame one cycle after entering IDLE
                if (hold_eop_q) begin
                    emit       = 1'b1;
                    emit_eop   = 1'b1;
                    hold_vld_d = 1'b0;
                    hold_eop_d = 1'b0;
                end
                take_start = 1'b1;
            end
            ST_DATA: begin
                if (start_lead) begin
                    close      = 1'b1;
                    close_err  = ERR_START;
                    take_start = 1'b1;
                end else if (all_data) begin
                    if (over_full) begin
                        close     = 1'b1;
                        close_err = ERR_OVER;
                        state_d   = ST_DROP;
                    end else begin
                        emit        = hold_vld_q;
                        hold_vld_d  = 1'b1;
                        hold_dat_d  = in_dat_q;
                        hold_keep_d = '1;
                        hold_sop_d  = sop_pend_q;
                        sop_pend_d  = 1'b0;
                        cnt_d       = cnt_q + 16'd8;
                    end
                end else if (term_ok) begin
                    if (first_ctl == 3'd0) begin
                        close   = 1'b1;
                        state_d = ST_IDLE;
                    end else if (over_term) begin
                        close     = 1'b1;
                        close_err = ERR_OVER;
                        state_d   = ST_DROP;
                    end else begin
                        emit        = hold_vld_q;
                        hold_vld_d  = 1'b1;
                        hold_dat_d  = term_dat;
                        hold_keep_d = term_keep;
                        hold_sop_d  = sop_pend_q;
                        hold_eop_d  = 1'b1;
                        sop_pend_d  = 1'b0;
                        cnt_d       = cnt_q + {13'd0, first_ctl};
                        state_d     = ST_IDLE;
                    end
                end else begin
                    close     = 1'b1;
                    close_err = ERR_CTRL;
                    state_d   = ST_DROP;
                end
            end
            ST_DROP: begin
                if (start_lead)                take_start = 1'b1;
                else if (has_term || all_idle) state_d    = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase

        // Close the frame on the held word; an empty hold yields a keep=00 eop word
        if (close) begin
            emit       = 1'b1;
            emit_eop   = 1'b1;
            emit_err   = close_err;
            hold_vld_d = 1'b0;
            hold_eop_d = 1'b0;
            sop_pend_d = 1'b0;
        end

        // Start handling is shared by IDLE, DROP and a restart inside DATA
        if (take_start && start_lead) begin
            if (pre_ok) begin
                state_d    = ST_DATA;
                sop_pend_d = 1'b1;
                cnt_d      = 16'd0;
            end else begin
                pre_err_d = 1'b1;
                state_d   = ST_IDLE;
            end
        end

        out_vld_d  = emit;
        out_dat_d  = (emit && hold_vld_q) ? hold_dat_q  : '0;
        out_keep_d = (emit && hold_vld_q) ? hold_keep_q : '0;
        out_sop_d  = emit && (hold_vld_q ? hold_sop_q : sop_pend_q);
        out_eop_d  = emit_eop;
        out_len_d  = emit_eop ? cnt_q : 16'd0;
        out_runt_d = emit_eop && (cnt_q < 16'(MIN_FRAME_BYTES));
        out_err_d  = emit_eop ? emit_err : ERR_NONE;
    end

    always_ff @(posedge clk) begin
        if (!i_rst_n) begin
            in_dat_q    <= '0;
            in_ctl_q    <= '0;
            state_q     <= ST_IDLE;
            hold_vld_q  <= 1'b0;
            hold_dat_q  <= '0;
            hold_keep_q <= '0;
            hold_sop_q  <= 1'b0;
            hold_eop_q  <= 1'b0;
            sop_pend_q  <= 1'b0;
            cnt_q       <= 16'd0;
            out_dat_q   <= '0;
            out_keep_q  <= '0;
            out_vld_q   <= 1'b0;
            out_sop_q   <= 1'b0;
            out_eop_q   <= 1'b0;
            out_len_q   <= 16'd0;
            out_runt_q  <= 1'b0;
            out_err_q   <= 2'd0;
            pre_err_q   <= 1'b0;
        end else begin
            in_dat_q    <= i_mii_data;
            in_ctl_q    <= i_mii_ctrl;
            state_q     <= state_d;
            hold_vld_q  <= hold_vld_d;
            hold_dat_q  <= hold_dat_d;
            hold_keep_q <= hold_keep_d;
            hold_sop_q  <= hold_sop_d;
            hold_eop_q  <= hold_eop_d;
            sop_pend_q  <= sop_pend_d;
            cnt_q       <= cnt_d;
            out_dat_q   <= out_dat_d;
            out_keep_q  <= out_keep_d;
            out_vld_q   <= out_vld_d;
            out_sop_q   <= out_sop_d;
            out_eop_q   <= out_eop_d;
            out_len_q   <= out_len_d;
            out_runt_q  <= out_runt_d;
            out_err_q   <= out_err_d;
            pre_err_q   <= pre_err_d;
        end
    end

    assign o_data      = out_dat_q;
    assign o_keep      = out_keep_q;
    assign o_valid     = out_vld_q;
    assign o_sop       = out_sop_q;
    assign o_eop       = out_eop_q;
    assign o_frame_len = out_len_q;
    assign o_runt      = out_runt_q;
    assign o_err_type  = out_err_q;
    assign o_pre_err   = pre_err_q;

endmodule

// File: tb/tb_mii_rx_deframer.sv
// Purpose : directed checks of mii_rx_deframer framing, status and error paths.
// Latency : first data word expected on o_data 2 edges after it is sampled.
// Backpressure: none; stimulus is a free-running MII word stream.
module tb_mii_rx_deframer;

    localparam logic [63:0] IDLE_W  = {8{8'h07}};
    localparam logic [63:0] START_W = 64'hD555_5555_5555_55FB;

    typedef struct packed {
        logic [63:0] d;
        logic [7:0]  k;
        logic        sop;
        logic        eop;
        logic [15:0] len;
        logic        runt;
        logic [1:0]  err;
        logic [31:0] cyc;
    } word_t;

    logic        clk;
    logic        i_rst_n;
    logic [63:0] i_mii_data;
    logic [7:0]  i_mii_ctrl;
    logic [63:0] o_data;
    logic [7:0]  o_keep;
    logic        o_valid, o_sop, o_eop, o_runt, o_pre_err;
    logic [15:0] o_frame_len;
    logic [1:0]  o_err_type;

    int          n_tests = 0;
    int          n_fail  = 0;
    int          pre_cnt = 0;
    logic [31:0] cyc = 0;
    logic [31:0] t_first;
    logic [31:0] first_cyc;
    word_t       q[$];
    word_t       mw;

    mii_rx_deframer dut (
        .clk         (clk),
        .i_rst_n     (i_rst_n),
        .i_mii_data  (i_mii_data),
        .i_mii_ctrl  (i_mii_ctrl),
        .o_data      (o_data),
        .o_keep      (o_keep),
        .o_valid     (o_valid),
        .o_sop       (o_sop),
        .o_eop       (o_eop),
        .o_frame_len (o_frame_len),
        .o_runt      (o_runt),
        .o_err_type  (o_err_type),
        .o_pre_err   (o_pre_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Output monitor, sampled on the falling edge
    always @(negedge clk) begin
        if (o_pre_err) pre_cnt++;
        if (o_valid) begin
            mw.d    = o_data;
            mw.k    = o_keep;
            mw.sop  = o_sop;
            mw.eop  = o_eop;
            mw.len  = o_frame_len;
            mw.runt = o_runt;
            mw.err  = o_err_type;
            mw.cyc  = cyc;
            q.push_back(mw);
        end else begin
            check("idle_qual", 64'({o_sop, o_eop, o_keep, o_frame_len, o_runt, o_err_type}), 64'd0);
        end
    end

    function automatic logic [63:0] kmask(input logic [7:0] k);
        logic [63:0] m;
        for (int i = 0; i < 8; i++) m[8*i +: 8] = {8{k[i]}};
        return m;
    endfunction

    task automatic drive(input logic [63:0] d, input logic [7:0] c);
        i_mii_data = d;
        i_mii_ctrl = c;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) drive(IDLE_W, 8'hFF);
    endtask

    // Terminate in lane k with data byte b in lanes 0..k-1
    task automatic send_term(input logic [7:0] b, input int k);
        logic [63:0] d;
        logic [7:0]  c;
        for (int i = 0; i < 8; i++) begin
            if (i < k) begin
                d[8*i +: 8] = b;
                c[i]        = 1'b0;
            end else if (i == k) begin
                d[8*i +: 8] = 8'hFD;
                c[i]        = 1'b1;
            end else begin
                d[8*i +: 8] = 8'h07;
                c[i]        = 1'b1;
            end
        end
        drive(d, c);
    endtask

    task automatic send_data(input logic [7:0] base, input int n);
        logic [7:0] b;
        for (int i = 1; i <= n; i++) begin
            b = base + 8'(i);
            drive({8{b}}, 8'h00);
        end
    endtask

    // Word i (1-based) carries byte base+i; the terminate word continues the sequence
    task automatic send_frame(input logic [7:0] base, input int nfull, input int k);
        drive(START_W, 8'h01);
        t_first = cyc;
        send_data(base, nfull);
        send_term(base + 8'(nfull + 1), k);
    endtask

    task automatic check_frame(input string tag, input int n, input int len, input logic runt,
                               input logic [1:0] err, input logic [7:0] last_keep, input logic [7:0] base);
        word_t       w;
        logic [7:0]  ek;
        logic [7:0]  b;
        logic [63:0] m;
        check({tag, "_nwords"}, 64'(q.size() >= n), 64'd1);
        for (int i = 0; i < n; i++) begin
            if (q.size() == 0) break;
            w = q.pop_front();
            if (i == 0) first_cyc = w.cyc;
            ek = (i == n - 1) ? last_keep : 8'hFF;
            m  = kmask(ek);
            b  = base + 8'(i + 1);
            check({tag, "_sop"},  64'(w.sop), 64'(i == 0));
            check({tag, "_eop"},  64'(w.eop), 64'(i == n - 1));
            check({tag, "_keep"}, 64'(w.k), 64'(ek));
            check({tag, "_data"}, w.d & m, {8{b}} & m);
            if (i == n - 1) begin
                check({tag, "_len"},  64'(w.len), 64'(len));
                check({tag, "_runt"}, 64'(w.runt), 64'(runt));
                check({tag, "_err"},  64'(w.err), 64'(err));
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int          p0;
        logic [63:0] d;

        i_rst_n    = 1'b0;
        i_mii_data = IDLE_W;
        i_mii_ctrl = 8'hFF;
        repeat (3) @(posedge clk);
        #1;
        check("rst_valid", 64'(o_valid), 64'd0);
        check("rst_data",  o_data, 64'd0);
        check("rst_qual",  64'({o_sop, o_eop, o_keep, o_frame_len, o_runt, o_err_type, o_pre_err}), 64'd0);
        i_rst_n = 1'b1;
        idle(3);

        // 64-byte frame, terminate in lane 0
        send_frame(8'h10, 8, 0);
        idle(6);
        check_frame("f64", 8, 64, 1'b0, 2'd0, 8'hFF, 8'h10);
        check("f64_latency", 64'(first_cyc), 64'(t_first + 3));
        check("f64_extra", 64'(q.size()), 64'd0);

        // 60-byte runt, terminate in lane 4
        send_frame(8'h20, 7, 4);
        idle(6);
        check_frame("f60", 8, 60, 1'b1, 2'd0, 8'h0F, 8'h20);

        // Bad preamble (lane 3 = 0x54), then a normal frame
        p0 = pre_cnt;
        drive(64'hD555_5555_5455_55FB, 8'h01);
        idle(5);
        check("pre_pulse", 64'(pre_cnt - p0), 64'd1);
        check("pre_novalid", 64'(q.size()), 64'd0);
        send_frame(8'h30, 9, 2);
        idle(6);
        check_frame("pre_next", 10, 74, 1'b0, 2'd0, 8'h03, 8'h30);

        // Bad control character in lane 2 of the 4th data word
        drive(START_W, 8'h01);
        send_data(8'h40, 3);
        d = {8{8'h44}};
        d[23:16] = 8'hFE;
        drive(d, 8'h04);
        drive({8{8'h45}}, 8'h00);
        drive({8{8'h46}}, 8'h00);
        send_term(8'h47, 0);
        idle(6);
        check_frame("ctl", 3, 24, 1'b1, 2'd1, 8'hFF, 8'h40);
        check("ctl_drop", 64'(q.size()), 64'd0);
        send_frame(8'h50, 8, 0);
        idle(6);
        check_frame("ctl_next", 8, 64, 1'b0, 2'd0, 8'hFF, 8'h50);

        // Oversize: 191 full words
        drive(START_W, 8'h01);
        send_data(8'h60, 191);
        send_term(8'h00, 0);
        idle(6);
        check_frame("over", 189, 1512, 1'b0, 2'd2, 8'hFF, 8'h60);
        check("over_drop", 64'(q.size()), 64'd0);

        // Start inside a frame after 5 words
        drive(START_W, 8'h01);
        send_data(8'h70, 5);
        send_frame(8'h80, 8, 0);
        idle(6);
        check_frame("sif_a", 5, 40, 1'b1, 2'd3, 8'hFF, 8'h70);
        check_frame("sif_b", 8, 64, 1'b0, 2'd0, 8'hFF, 8'h80);

        // Zero data bytes
        drive(START_W, 8'h01);
        send_term(8'h00, 0);
        idle(4);
        check_frame("zero", 1, 0, 1'b1, 2'd0, 8'h00, 8'h00);

        // Back-to-back frames with no idle gap
        send_frame(8'h90, 2, 3);
        send_frame(8'hA0, 2, 5);
        idle(6);
        check_frame("b2b_a", 3, 19, 1'b1, 2'd0, 8'h07, 8'h90);
        check_frame("b2b_b", 3, 21, 1'b1, 2'd0, 8'h1F, 8'hA0);

        // FB in lane 2 is not a start
        p0 = pre_cnt;
        drive(64'hD555_5555_55FB_5555, 8'h04);
        send_data(8'h11, 3);
        send_term(8'h15, 0);
        idle(4);
        check("fb_lane2_novalid", 64'(q.size()), 64'd0);
        check("fb_lane2_nopre", 64'(pre_cnt - p0), 64'd0);

        // Reset in the middle of a frame
        drive(START_W, 8'h01);
        send_data(8'hB0, 3);
        i_rst_n = 1'b0;
        drive({8{8'hB4}}, 8'h00);
        check("rstmid_valid", 64'(o_valid), 64'd0);
        check("rstmid_out", 64'({o_sop, o_eop, o_keep, o_data}), 64'd0);
        i_rst_n = 1'b1;
        drive({8{8'hB5}}, 8'h00);
        send_term(8'hB6, 0);
        idle(4);
        check("rstmid_words", 64'(q.size()), 64'd1);
        if (q.size() > 0) check("rstmid_noeop", 64'(q[0].eop), 64'd0);
        q.delete();
        send_frame(8'hC0, 8, 0);
        idle(6);
        check_frame("post_rst", 8, 64, 1'b0, 2'd0, 8'hFF, 8'hC0);
        check("final_empty", 64'(q.size()), 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/mii_rx_deframer.md
Name: mii_rx_deframer

Overview:
- Receive-side framing stage. Consumes the 64-bit data / 8-bit control MII word stream produced by the MAC/MII generator.
- Strips the start/preamble/SFD word and removes idle and terminate characters.
- Emits a byte-qualified frame stream (sop/eop/keep) plus per-frame length and error status for the MAC-level checker downstream.
- Lane 0 (bits 7:0, control bit 0) is first on the wire.

Parameters:
- DATA_WIDTH, 64, MII data width (fixed 8 lanes)
- CTRL_WIDTH, 8, one control bit per lane
- IDLE_CODE, 8'h07, idle control character
- START_CODE, 8'hFB, start control character
- TERM_CODE, 8'hFD, terminate control character
- PREAMBLE_CODE, 8'h55, preamble byte
- SFD_CODE, 8'hD5, start-of-frame delimiter
- MIN_FRAME_BYTES, 64, runt threshold (DA through FCS)
- MAX_FRAME_BYTES, 1518, oversize threshold

Ports:
- clk  input  1  clock; all logic on rising edge
- i_rst_n  input  1  synchronous active-low reset
- i_mii_data  input  64  MII data word, lane k = bits 8k+7:8k
- i_mii_ctrl  input  8  bit k set = lane k is a control character
- o_data  output  64  frame bytes, lane 0 first
- o_keep  output  8  byte-valid mask, contiguous from lane 0
- o_valid  output  1  output word valid
- o_sop  output  1  first word of frame
- o_eop  output  1  last word of frame
- o_frame_len  output  16  frame byte count; valid with o_eop
- o_runt  output  1  o_frame_len < MIN_FRAME_BYTES; valid with o_eop
- o_err_type  output  2  0 none, 1 bad control/tail, 2 oversize, 3 start inside frame; valid with o_eop
- o_pre_err  output  1  one-cycle pulse: start word with bad preamble/SFD

Behaviour:
- Reset (i_rst_n=0 at a clk edge):
  - all outputs 0, state IDLE, hold register empty, byte counter 0.
  - Any partial frame is discarded silently (no eop emitted).
- Start word:
  - lane 0 = FB with ctrl=1; lanes 1-6 = 55 and lane 7 = D5, all with ctrl=0.
  - FB with ctrl set in any lane other than 0 is ignored; stay IDLE.
- Pipeline:
  - input register, then a one-word hold register.
  - A data word accepted at edge t is driven on the outputs after edge t+2 (2-cycle latency).
  - The hold register exists so eop can be placed on the last data word.
- States: IDLE, DATA, DROP.
- IDLE:
  - valid start word → DATA; counter = 0; next emitted word carries o_sop=1.
  - Start with any mismatching preamble/SFD byte → o_pre_err=1 for one cycle; stay IDLE; nothing emitted.
  - All other words are ignored.
- DATA, word with all ctrl=0:
  - held word (if any) emitted with keep=FF.
  - new word enters hold.
  - counter += 8.
- DATA, terminate in lane k (FD, ctrl bit k=1, ctrl bits 0..k-1 = 0):
  - Lanes k+1..7 must be 07 with ctrl=1.
  - k>0: held word emitted normally; terminate word emitted next cycle with keep=(1<<k)-1, eop=1; counter += k.
  - k=0: held word emitted with eop=1.
  - Zero data bytes (start then terminate lane 0): one word with valid=sop=eop=1, keep=00, len=0, runt=1.
  - → IDLE.
- DATA, ctrl set on a lane holding anything other than a valid terminate, or bad tail after FD:
  - held word emitted with eop=1, err_type=1 (if hold empty: keep=00 word).
  - → DROP.
- DATA, counter would exceed MAX_FRAME_BYTES on accepting a word:
  - that word is discarded.
  - held word emitted with eop=1, err_type=2.
  - → DROP.
- DATA, valid start word in lane 0:
  - held word emitted with eop=1, err_type=3.
  - New start is processed as in IDLE: good preamble → DATA with new sop; bad preamble → o_pre_err and IDLE.
- DROP:
  - discard all input.
  - Word containing terminate or all-idle → IDLE.
  - Valid start word → handled as in IDLE in the same cycle.
- Frame length and runt:
  - o_frame_len = bytes actually emitted for the frame, 16-bit, no wrap possible below MAX_FRAME_BYTES.
  - o_runt is evaluated on o_frame_len.
- Output qualifiers:
  - o_sop, o_eop, o_keep, o_frame_len, o_runt and o_err_type are 0 whenever o_valid=0.
  - o_sop and o_eop may both be 1 on the same word.
- Back-to-back frames:
  - Terminate in lane k<7 followed by a start word on the next cycle needs no idle gap.
  - The downstream eop of one frame and the sop of the next may occur on consecutive cycles.

Test Plan:
- 64-byte frame: start word, 8 words of 0xAA.., terminate lane 0 + 7×07 → 8 valid words; sop on 1st, eop on 8th, keep FF, len=64, runt=0, err=0; first o_valid 2 cycles after 1st data word.
- 60-byte frame: 7 full words, then terminate in lane 4 → 8 words, last keep=0F with eop, len=60, runt=1.
- Bad preamble, lane 3 = 0x54 → o_pre_err high exactly 1 cycle; no o_valid; following valid frame received normally.
- Control 0xFE (ctrl=1) in lane 2 of the 4th data word → eop on 3rd word, err_type=1, len=24; remaining words dropped until terminate; next frame OK.
- Oversize, MAX_FRAME_BYTES=1518, 191 full data words → eop on word 189, err_type=2, len=1512; tail dropped.
- Start word arrives after 5 data words without terminate → eop on word 5, err_type=3, len=40; new frame gets sop. Reset asserted mid-frame → outputs 0 next cycle, no eop.
